// File: rtl/fp_serial_loader.sv
// 8N1 UART program loader for the SAP-1 front-panel port: receives HDR, 16 data
// bytes and a mod-256 checksum, writes them into program memory, then releases clear.
module fp_serial_loader #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         WR_CYCLES    = 2,
    parameter int         CLR_CYCLES   = 4,
    parameter logic [7:0] HDR_BYTE     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic       fp_prog,
    output logic       fp_write,
    output logic [3:0] fp_adr,
    output logic [7:0] fp_data,
    output logic       fp_clear,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int            TW      = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] T_HALF  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL  = TW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    WR_LAST  = 8'(WR_CYCLES - 1);
    localparam logic [7:0]    CLR_LAST = 8'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_DATA, S_SETUP, S_WRITE, S_HOLD, S_WAIT_SUM, S_RELEASE, S_ERROR
    } state_t;

    logic          rx_m, rx_s, rx_d;
    rx_state_t     rstate;
    logic [TW-1:0] tmr;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          byte_valid, frame_error;

    state_t     state;
    logic [3:0] idx;
    logic [7:0] sum, cnt, hold_byte;
    logic       hold_vld, load_ok;
    logic       avail, take;
    logic [7:0] in_byte;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // Bit timer restarts at the start-bit edge so every later sample lands mid-bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rstate      <= R_IDLE;
            tmr         <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
            case (rstate)
                R_IDLE: if (rx_d && !rx_s) begin
                    rstate <= R_START;
                    tmr    <= '0;
                end
                R_START: if (tmr == T_HALF) begin
                    tmr     <= '0;
                    bit_cnt <= '0;
                    rstate  <= rx_s ? R_IDLE : R_DATA;
                end else tmr <= tmr + 1'b1;
                R_DATA: if (tmr == T_FULL) begin
                    tmr     <= '0;
                    shreg   <= {rx_s, shreg[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) rstate <= R_STOP;
                end else tmr <= tmr + 1'b1;
                default: if (tmr == T_FULL) begin
                    rstate <= R_IDLE;
                    if (rx_s) byte_valid <= 1'b1;
                    else      frame_error <= 1'b1;
                end else tmr <= tmr + 1'b1;
            endcase
        end
    end

    // A fresh byte is consumed directly; the holding register only covers SETUP/WRITE/HOLD/RELEASE.
    assign avail   = hold_vld | byte_valid;
    assign in_byte = hold_vld ? hold_byte : shreg;
    assign take    = avail && (state inside {S_IDLE, S_WAIT_DATA, S_WAIT_SUM, S_ERROR});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_RELEASE;
            fp_prog   <= 1'b0;
            fp_write  <= 1'b0;
            fp_adr    <= '0;
            fp_data   <= '0;
            fp_clear  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cnt       <= '0;
            load_ok   <= 1'b0;
            hold_vld  <= 1'b0;
            hold_byte <= '0;
        end else begin
            done <= 1'b0;
            if (byte_valid && (hold_vld || !take)) begin
                hold_byte <= shreg;
                hold_vld  <= 1'b1;
            end else if (take) hold_vld <= 1'b0;

            if (frame_error &&
                (state inside {S_WAIT_DATA, S_SETUP, S_WRITE, S_HOLD, S_WAIT_SUM})) begin
                state    <= S_ERROR;
                err      <= 1'b1;
                busy     <= 1'b0;
                fp_prog  <= 1'b0;
                fp_write <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_ERROR: if (take && in_byte == HDR_BYTE) begin
                        idx      <= '0;
                        sum      <= '0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        fp_clear <= 1'b1;
                        fp_prog  <= 1'b1;
                        load_ok  <= 1'b0;
                        state    <= S_WAIT_DATA;
                    end
                    S_WAIT_DATA: if (take) begin
                        fp_data <= in_byte;
                        fp_adr  <= idx;
                        sum     <= sum + in_byte;
                        state   <= S_SETUP;
                    end
                    S_SETUP: begin
                        fp_write <= 1'b1;
                        cnt      <= '0;
                        state    <= S_WRITE;
                    end
                    S_WRITE: if (cnt == WR_LAST) begin
                        fp_write <= 1'b0;
                        state    <= S_HOLD;
                    end else cnt <= cnt + 1'b1;
                    S_HOLD: if (idx == 4'd15) state <= S_WAIT_SUM;
                    else begin
                        idx   <= idx + 1'b1;
                        state <= S_WAIT_DATA;
                    end
                    S_WAIT_SUM: if (take) begin
                        fp_prog <= 1'b0;
                        cnt     <= '0;
                        if (in_byte == sum) begin
                            load_ok <= 1'b1;
                            state   <= S_RELEASE;
                        end else begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_ERROR;
                        end
                    end
                    S_RELEASE: if (cnt == CLR_LAST) begin
                        fp_clear <= 1'b0;
                        busy     <= 1'b0;
                        done     <= load_ok;
                        load_ok  <= 1'b0;
                        state    <= S_IDLE;
                    end else cnt <= cnt + 1'b1;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fp_serial_loader.sv
// Directed bench for fp_serial_loader: drives UART frames and watches the
// programming port against a behavioural memory model.
module tb_fp_serial_loader;
    localparam int CPB = 8;
    localparam int BIT = CPB * 10;

    logic       clk = 1'b0, reset_n = 1'b0, rx = 1'b1;
    logic       fp_prog, fp_write, fp_clear, busy, done, err;
    logic [3:0] fp_adr;
    logic [7:0] fp_data;

    fp_serial_loader #(.CLKS_PER_BIT(CPB), .WR_CYCLES(2), .CLR_CYCLES(4), .HDR_BYTE(8'hA5)) dut (
        .clk(clk), .reset_n(reset_n), .rx(rx), .fp_prog(fp_prog), .fp_write(fp_write),
        .fp_adr(fp_adr), .fp_data(fp_data), .fp_clear(fp_clear), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Memory model plus a log of every fp_write pulse.
    logic [7:0] mem [16];
    int wr_adr[$], wr_dat[$], wr_len[$];
    int hi_len = 0, viol = 0, n_done = 0;
    initial begin
        logic       wr_d;
        logic [3:0] a0;
        logic [7:0] d0;
        wr_d = 1'b0; a0 = '0; d0 = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (fp_write) begin
                mem[fp_adr] = fp_data;
                if (!wr_d) begin a0 = fp_adr; d0 = fp_data; hi_len = 0; end
                hi_len++;
                if (!fp_prog || fp_adr != a0 || fp_data != d0) viol++;
            end else if (wr_d) begin
                wr_adr.push_back(int'(a0));
                wr_dat.push_back(int'(d0));
                wr_len.push_back(hi_len);
            end
            wr_d = fp_write;
            if (done) n_done++;
        end
    end

    logic [7:0] img [16];

    function automatic logic [7:0] img_sum();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 16; i++) s = s + img[i];
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0; #(BIT);
        for (int i = 0; i < 8; i++) begin rx = b[i]; #(BIT); end
        rx = stop; #(BIT);
        rx = 1'b1; #(BIT);
    endtask

    // bad >= 0 sends data byte 'bad' with a zero stop bit and ends the frame there.
    task automatic send_frame(input logic [7:0] cs, input int bad);
        logic aborted = 1'b0;
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 16 && !aborted; i++) begin
            send_byte(img[i], i != bad);
            if (i == bad) aborted = 1'b1;
        end
        if (!aborted) send_byte(cs, 1'b1);
        repeat (20) @(posedge clk);
    endtask

    function automatic int mem_ok();
        int n = 0;
        for (int i = 0; i < 16; i++) if (mem[i] === img[i]) n++;
        return n;
    endfunction

    int base, dbase, n;

    initial begin
        // reset state and clear release length
        repeat (3) @(posedge clk);
        #1;
        chk("rst_prog", fp_prog, 0);  chk("rst_write", fp_write, 0);
        chk("rst_adr", fp_adr, 0);    chk("rst_data", fp_data, 0);
        chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
        chk("rst_err", err, 0);       chk("rst_clear", fp_clear, 1);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (fp_clear && n < 20);
        chk("clr_len", n, 4);
        repeat (5) @(posedge clk);
        chk("rst_no_done", n_done, 0);

        // good load 00..0F
        for (int i = 0; i < 16; i++) img[i] = 8'(i);
        base = wr_adr.size(); dbase = n_done;
        send_frame(8'h78, -1);
        chk("good_nwr", wr_adr.size() - base, 16);
        for (int i = 0; i < 16; i++) if (base + i < wr_adr.size()) begin
            chk("good_adr", wr_adr[base+i], i);
            chk("good_dat", wr_dat[base+i], i);
            chk("good_len", wr_len[base+i], 2);
        end
        chk("good_mem", mem_ok(), 16);
        chk("good_done", n_done - dbase, 1);
        chk("good_err", err, 0);   chk("good_busy", busy, 0);
        chk("good_clear", fp_clear, 0); chk("good_prog", fp_prog, 0);

        // stop bit 0 on D5 aborts after five writes
        for (int i = 0; i < 16; i++) img[i] = 8'(8'h40 + i);
        base = wr_adr.size(); dbase = n_done;
        send_frame(8'h00, 5);
        chk("ferr_nwr", wr_adr.size() - base, 5);
        if (base + 4 < wr_adr.size()) chk("ferr_last_adr", wr_adr[base+4], 4);
        chk("ferr_mem4", mem[4], 8'h44);
        chk("ferr_mem5", mem[5], 8'h05);
        chk("ferr_err", err, 1);     chk("ferr_busy", busy, 0);
        chk("ferr_clear", fp_clear, 1); chk("ferr_prog", fp_prog, 0);
        chk("ferr_done", n_done - dbase, 0);

        // bad checksum, then a good frame recovers
        for (int i = 0; i < 16; i++) img[i] = 8'(i);
        base = wr_adr.size(); dbase = n_done;
        send_frame(8'h79, -1);
        chk("csum_nwr", wr_adr.size() - base, 16);
        chk("csum_err", err, 1);  chk("csum_clear", fp_clear, 1);
        chk("csum_done", n_done - dbase, 0);
        dbase = n_done;
        send_frame(8'h78, -1);
        chk("rec_err", err, 0);   chk("rec_done", n_done - dbase, 1);
        chk("rec_clear", fp_clear, 0);

        // non-header bytes ignored in IDLE; A5 as data is plain data
        base = wr_adr.size(); dbase = n_done;
        send_byte(8'h3C, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (10) @(posedge clk);
        chk("ign_busy", busy, 0);
        chk("ign_nwr", wr_adr.size() - base, 0);
        for (int i = 0; i < 16; i++) img[i] = 8'(8'h10 + i);
        img[3] = 8'hA5;
        send_frame(img_sum(), -1);
        chk("hdr_nwr", wr_adr.size() - base, 16);
        if (base + 3 < wr_adr.size()) chk("hdr_d3_adr", wr_adr[base+3], 3);
        chk("hdr_d3_mem", mem[3], 8'hA5);
        chk("hdr_mem", mem_ok(), 16);
        chk("hdr_done", n_done - dbase, 1);

        // quarter-bit glitch must not desync the next frame
        @(negedge clk);
        rx = 1'b0; #(BIT / 4); rx = 1'b1;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 16; i++) img[i] = 8'(8'hF0 - 3 * i);
        base = wr_adr.size(); dbase = n_done;
        send_frame(img_sum(), -1);
        chk("glitch_done", n_done - dbase, 1);
        chk("glitch_mem", mem_ok(), 16);

        // reset in the middle of D7
        for (int i = 0; i < 16; i++) img[i] = 8'(8'h20 + i);
        base = wr_adr.size();
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 7; i++) send_byte(img[i], 1'b1);
        rx = 1'b0; #(BIT * 3);
        chk("mid_busy", busy, 1);  chk("mid_prog", fp_prog, 1);
        chk("mid_nwr", wr_adr.size() - base, 7);
        #3 reset_n = 1'b0;
        #2;
        chk("mrst_prog", fp_prog, 0);  chk("mrst_write", fp_write, 0);
        chk("mrst_adr", fp_adr, 0);    chk("mrst_data", fp_data, 0);
        chk("mrst_busy", busy, 0);     chk("mrst_err", err, 0);
        chk("mrst_clear", fp_clear, 1);
        chk("mrst_mem6", mem[6], 8'h26);
        rx = 1'b1;
        #(BIT * 2);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);

        chk("write_window", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
